// File: rtl/key_if.sv
// Bit-serial key link between a key source (master) and the sequencer (slave).
interface key_if;
  logic key_valid;
  logic key_bit;
  logic key_ready;
  logic key_clr;

  modport master (output key_valid, output key_bit, output key_clr, input key_ready);
  modport slave  (input key_valid, input key_bit, input key_clr, output key_ready);
endinterface

// File: rtl/key_load_sequencer.sv
// Loads a serial unlock key with even parity, applies it to a key-locked core and
// sequences its reset; define KEY_ZEROIZE_EN to let key_clr wipe an applied key.
module key_load_sequencer #(
  parameter int KEY_W     = 8,
  parameter int MAX_TRIES = 3,
  parameter int RST_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  key_if.slave             key,
  output logic [KEY_W-1:0] keyinput,
  output logic             fsm_rst,
  output logic             run,
  output logic             err,
  output logic             locked
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(KEY_W);
  localparam logic [7:0]       RST_LAST  = 8'(RST_CYC - 1);
  localparam logic [3:0]       TRY_LAST  = 4'(MAX_TRIES - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] CHECK   = 3'd2;
  localparam logic [2:0] APPLY   = 3'd3;
  localparam logic [2:0] RUN     = 3'd4;
  localparam logic [2:0] ERR     = 3'd5;
  localparam logic [2:0] LOCKOUT = 3'd6;

  logic [2:0]       state,   state_nxt;
  logic [KEY_W-1:0] key_reg, key_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_nxt;
  logic [3:0]       try_cnt, try_nxt;
  logic [7:0]       rst_cnt, rst_cnt_nxt;
  logic             par_bit, par_nxt;
  logic             xfer;

  assign xfer = key.key_valid & key.key_ready;

  // NOTE: every next-state variable takes its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    key_nxt     = key_reg;
    bit_nxt     = bit_cnt;
    try_nxt     = try_cnt;
    rst_cnt_nxt = rst_cnt;
    par_nxt     = par_bit;
    case (state)
      IDLE: begin
        if (xfer) begin
          key_nxt   = KEY_W'(key.key_bit);
          bit_nxt   = CNT_W'(1);
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // An abort outranks a bit arriving in the same cycle.
        if (key.key_clr) begin
          key_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = IDLE;
        end else if (xfer) begin
          if (bit_cnt == BITS_LAST) begin
            par_nxt   = key.key_bit;
            state_nxt = CHECK;
          end else begin
            key_nxt = key_reg | (KEY_W'(key.key_bit) << bit_cnt);
            bit_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      CHECK: begin
        bit_nxt = '0;
        if ((^key_reg ^ par_bit) == 1'b0) begin
          try_nxt     = '0;
          rst_cnt_nxt = '0;
          state_nxt   = APPLY;
        end else if (try_cnt == TRY_LAST) begin
          key_nxt   = '0;
          state_nxt = LOCKOUT;
        end else begin
          try_nxt   = (try_cnt == 4'hF) ? try_cnt : try_cnt + 4'd1;
          state_nxt = ERR;
        end
      end
      APPLY: begin
        rst_cnt_nxt = rst_cnt + 8'd1;
        if (rst_cnt == RST_LAST) state_nxt = RUN;
`ifdef KEY_ZEROIZE_EN
        if (key.key_clr) begin
          key_nxt   = '0;
          state_nxt = IDLE;
        end
`endif
      end
      RUN: begin
`ifdef KEY_ZEROIZE_EN
        if (key.key_clr) begin
          key_nxt   = '0;
          state_nxt = IDLE;
        end
`endif
      end
      ERR: begin
        key_nxt   = '0;
        bit_nxt   = '0;
        state_nxt = IDLE;
      end
      LOCKOUT: key_nxt = '0;
      default: begin
        key_nxt   = '0;
        bit_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  // Outputs are decoded from the next state so they are registered yet aligned
  // with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      key_reg       <= '0;
      bit_cnt       <= '0;
      try_cnt       <= '0;
      rst_cnt       <= '0;
      par_bit       <= 1'b0;
      keyinput      <= '0;
      fsm_rst       <= 1'b1;
      run           <= 1'b0;
      err           <= 1'b0;
      locked        <= 1'b0;
      key.key_ready <= 1'b0;
    end else begin
      state         <= state_nxt;
      key_reg       <= key_nxt;
      bit_cnt       <= bit_nxt;
      try_cnt       <= try_nxt;
      rst_cnt       <= rst_cnt_nxt;
      par_bit       <= par_nxt;
      keyinput      <= (state_nxt == APPLY || state_nxt == RUN) ? key_nxt : '0;
      fsm_rst       <= (state_nxt != RUN);
      run           <= (state_nxt == RUN);
      err           <= (state_nxt == ERR);
      locked        <= (state_nxt == LOCKOUT);
      key.key_ready <= (state_nxt == IDLE || state_nxt == LOAD);
    end
  end

endmodule

// File: tb/tb_key_load_sequencer.sv
// Randomized scoreboard bench for key_load_sequencer: stimulus pushes predicted
// outcomes, a negedge monitor pops them when run/err/locked fire.
module tb_key_load_sequencer;
  localparam int KEY_W     = 8;
  localparam int MAX_TRIES = 3;
  localparam int RST_CYC   = 4;

  typedef enum int {EV_RUN = 0, EV_ERR = 1, EV_LOCK = 2} ev_e;
  typedef struct {
    ev_e              kind;
    logic [KEY_W-1:0] key;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_if kif ();
  logic [KEY_W-1:0] keyinput;
  logic             fsm_rst, run, err, locked;

  key_load_sequencer #(.KEY_W(KEY_W), .MAX_TRIES(MAX_TRIES), .RST_CYC(RST_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (kif),
    .keyinput (keyinput),
    .fsm_rst  (fsm_rst),
    .run      (run),
    .err      (err),
    .locked   (locked)
  );

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   tries    = 0;   // model: consecutive parity failures since last good key or reset

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: even parity over key plus parity bit, lockout on the
  // MAX_TRIES-th consecutive failure.
  task automatic predict(input logic [KEY_W-1:0] k, input logic par, output ev_e kind);
    exp_t e;
    e.key = k;
    if ((($countones(k) + int'(par)) % 2) == 0) begin
      kind  = EV_RUN;
      tries = 0;
    end else if (tries + 1 == MAX_TRIES) begin
      kind  = EV_LOCK;
      tries = 0;
    end else begin
      kind  = EV_ERR;
      tries = tries + 1;
    end
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  task automatic take(input ev_e kind, output exp_t e);
    e.kind = kind;
    e.key  = '0;
    if (exp_q.size() == 0) check("unexpected_event", 32'(kind), 32'hFF);
    else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
    end
  endtask

  initial begin : monitor
    logic prev_run, prev_err, prev_locked;
    int   pre_cnt;
    exp_t e;
    prev_run = 0; prev_err = 0; prev_locked = 0; pre_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_run = 0; prev_err = 0; prev_locked = 0; pre_cnt = 0;
      end else begin
        if (err) begin
          if (prev_err) check("err_single_cycle", 32'(prev_err), 32'd0);
          else begin
            take(EV_ERR, e);
            check("err_keyinput", 32'(keyinput), 32'd0);
            check("err_fsm_rst", 32'(fsm_rst), 32'd1);
          end
        end
        if (locked && !prev_locked) begin
          take(EV_LOCK, e);
          check("lock_ready", 32'(kif.key_ready), 32'd0);
          check("lock_keyinput", 32'(keyinput), 32'd0);
          check("lock_fsm_rst", 32'(fsm_rst), 32'd1);
        end
        if (run && !prev_run) begin
          take(EV_RUN, e);
          check("run_keyinput", 32'(keyinput), 32'(e.key));
          check("run_fsm_rst", 32'(fsm_rst), 32'd0);
          check("run_ready", 32'(kif.key_ready), 32'd0);
          check("check_plus_apply_cycles", 32'(pre_cnt), 32'(RST_CYC + 1));
        end
        if (!kif.key_ready && fsm_rst && !err && !locked) pre_cnt++;
        else pre_cnt = 0;
        prev_run = run; prev_err = err; prev_locked = locked;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_bit(input logic b);
    int n = 0;
    if ($urandom_range(3) == 0) repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
    end
    kif.key_valid = 1'b1;
    kif.key_bit   = b;
    while (!kif.key_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!kif.key_ready) check("key_ready_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
    end
    kif.key_valid = 1'b0;
  endtask

  task automatic send_key(input logic [KEY_W-1:0] k, input logic par, output ev_e kind);
    predict(k, par, kind);
    for (int i = 0; i < KEY_W; i++) drive_bit(k[i]);
    drive_bit(par);
  endtask

  task automatic wait_outcome();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("outcome_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_keyinput", 32'(keyinput), 32'd0);
    check("rst_fsm_rst", 32'(fsm_rst), 32'd1);
    check("rst_ready", 32'(kif.key_ready), 32'd0);
    check("rst_run_err_locked", {29'd0, run, err, locked}, 32'd0);
    exp_q.delete();
    tries = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(kif.key_ready), 32'd1);
  endtask

  task automatic after_run(input logic [KEY_W-1:0] k);
    kif.key_clr = 1'b1;
    @(posedge clk); #1;
    kif.key_clr = 1'b0;
`ifdef KEY_ZEROIZE_EN
    check("zeroize_keyinput", 32'(keyinput), 32'd0);
    check("zeroize_fsm_rst", 32'(fsm_rst), 32'd1);
    check("zeroize_run", 32'(run), 32'd0);
    check("zeroize_idle_ready", 32'(kif.key_ready), 32'd1);
`else
    check("clr_run_keyinput", 32'(keyinput), 32'(k));
    check("clr_run_run", 32'(run), 32'd1);
    check("clr_run_fsm_rst", 32'(fsm_rst), 32'd0);
    do_reset();
`endif
  endtask

  task automatic lock_ignore();
    kif.key_valid = 1'b1;
    for (int i = 0; i < 2 * (KEY_W + 1); i++) begin
      kif.key_bit = ((8'hA5 >> (i % 8)) & 8'h01) != 0;
      kif.key_clr = $urandom_range(4) == 0;
      @(posedge clk); #1;
    end
    kif.key_valid = 1'b0;
    kif.key_clr   = 1'b0;
    check("lock_hold_locked", 32'(locked), 32'd1);
    check("lock_hold_keyinput", 32'(keyinput), 32'd0);
    check("lock_hold_ready", 32'(kif.key_ready), 32'd0);
    do_reset();
  endtask

  task automatic abort_after(input logic [KEY_W-1:0] k, input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(k[i]);
    kif.key_valid = 1'b1;
    kif.key_bit   = 1'b1;
    kif.key_clr   = 1'b1;
    @(posedge clk); #1;
    kif.key_valid = 1'b0;
    kif.key_clr   = 1'b0;
    check("abort_idle_ready", 32'(kif.key_ready), 32'd1);
    check("abort_keyinput", 32'(keyinput), 32'd0);
  endtask

  task automatic run_load(input logic [KEY_W-1:0] k, input logic par);
    ev_e kind;
    send_key(k, par, kind);
    wait_outcome();
    if (kind == EV_RUN) after_run(k);
    else if (kind == EV_LOCK) lock_ignore();
    else begin
      check("post_err_ready", 32'(kif.key_ready), 32'd1);
      check("post_err_locked", 32'(locked), 32'd0);
    end
  endtask

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    ev_e kind;
    logic [KEY_W-1:0] k;
    logic par;
    kif.key_valid = 1'b0;
    kif.key_bit   = 1'b0;
    kif.key_clr   = 1'b0;
    do_reset();

    run_load(8'hA5, 1'b0);              // good key reaches RUN
    run_load(8'hA5, 1'b1);              // bad parity -> err
    run_load(8'h5A, 1'b1);
    run_load(8'h01, 1'b0);              // third consecutive failure -> lockout

    abort_after(8'hFF, 3);              // clr beats a simultaneous bit
    run_load(8'h3C, 1'b0);

    run_load(8'h0F, 1'b1);              // bad, good, bad, bad: no lockout
    run_load(8'h0F, 1'b0);
    run_load(8'h81, 1'b1);
    run_load(8'h7E, 1'b1);

    run_load(8'h11, 1'b1);              // abort does not count as a try
    abort_after(8'h22, 5);
    run_load(8'h33, 1'b1);

    // Asynchronous reset on the second APPLY cycle.
    send_key(8'hA5, 1'b0, kind);
    @(posedge clk); #1;
    check("apply1_keyinput", 32'(keyinput), 32'hA5);
    check("apply1_fsm_rst", 32'(fsm_rst), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("async_rst_keyinput", 32'(keyinput), 32'd0);
    check("async_rst_fsm_rst", 32'(fsm_rst), 32'd1);
    check("async_rst_run", 32'(run), 32'd0);
    exp_q.delete();
    tries = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("async_rst_release_ready", 32'(kif.key_ready), 32'd1);

    for (int it = 0; it < 60; it++) begin
      k   = KEY_W'($urandom);
      par = ($countones(k) % 2) != 0;
      if ($urandom_range(9) < 4) par = ~par;
      if ($urandom_range(9) < 2) abort_after(k, int'($urandom_range(1, KEY_W)));
      else run_load(k, par);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_load_sequencer.md
Name: key_load_sequencer

Overview:
- Controller that configures and sequences a key-locked FSM benchmark core.
- Accepts a KEY_W-bit unlock key over a bit-serial valid/ready link, followed by one even-parity bit, and checks the parity.
- On a good key, drives the core's keyinput bus and holds the core in reset for RST_CYC cycles, then releases it.
- Counts consecutive parity failures and locks out permanently after MAX_TRIES.

Parameters:
KEY_W, 8, key width and width of the keyinput bus (1..32)
MAX_TRIES, 3, consecutive parity failures that trigger lockout (1..15)
RST_CYC, 4, cycles fsm_rst is held high in APPLY (1..255)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
key_valid  input  1  serial key bit valid
key_bit  input  1  serial key data; LSB first, then parity bit
key_ready  output  1  sequencer accepts a bit this cycle
key_clr  input  1  abort or clear request
keyinput  output  KEY_W  key bus to the locked core (registered)
fsm_rst  output  1  active-high reset to the locked core
run  output  1  key applied and core running
err  output  1  one-cycle pulse on a parity failure
locked  output  1  lockout reached

Behaviour:
- Reset (rst=0, asynchronous, any state): state=IDLE, key_reg=0, bit_cnt=0, try_cnt=0, rst_cnt=0.
  - Outputs on reset: keyinput=0, fsm_rst=1, key_ready=0, run=0, err=0, locked=0.
  - Effect is immediate, including mid-LOAD or mid-APPLY.
- A transfer occurs when key_valid=1 and key_ready=1 at a rising edge.
- key_ready=1 only in IDLE and LOAD; it is registered and is 1 the first cycle after reset release.
- IDLE:
  - On a transfer: key_reg[0]=key_bit, bit_cnt=1, go to LOAD.
  - key_clr: no effect.
- LOAD:
  - While bit_cnt<KEY_W, a transfer stores key_reg[bit_cnt]=key_bit and increments bit_cnt.
  - A transfer at bit_cnt==KEY_W is the parity bit. Latch it, go to CHECK; key_ready=0 from the next cycle.
  - key_valid=0: hold; there is no timeout.
  - key_clr=1: key_reg=0, bit_cnt=0, go to IDLE. Does not count as a try. key_clr wins over a simultaneous transfer, whose bit is discarded.
- CHECK (exactly 1 cycle):
  - Pass when XOR of key_reg and the parity bit is 0: try_cnt=0, rst_cnt=0, go to APPLY.
  - Fail when try_cnt+1==MAX_TRIES: go to LOCKOUT.
  - Fail otherwise: try_cnt+=1, go to ERR.
- APPLY:
  - keyinput=key_reg from the first APPLY cycle; fsm_rst=1.
  - rst_cnt increments each cycle; when rst_cnt==RST_CYC-1, go to RUN.
  - fsm_rst is therefore high for exactly RST_CYC APPLY cycles.
- RUN:
  - fsm_rst=0, run=1, keyinput holds key_reg.
  - key_valid ignored; key_clr handling per Optional Feature.
- ERR (1 cycle): err=1, key_reg=0, bit_cnt=0, keyinput=0, fsm_rst=1, then IDLE.
- LOCKOUT:
  - locked=1, key_ready=0, fsm_rst=1, keyinput=0, key_reg=0.
  - All inputs ignored; only rst exits.
- keyinput is nonzero only in APPLY and RUN.
- try_cnt is 4 bits and saturates.

Optional Feature:
- Macro: KEY_ZEROIZE_EN.
- Defined: key_clr=1 in APPLY or RUN sets key_reg=0 and keyinput=0 next cycle, fsm_rst=1, run=0, state=IDLE. try_cnt is unchanged.
- Not defined: key_clr is ignored in APPLY and RUN; the key persists until rst.

Test Plan:
- Serial 0xA5 (1,0,1,0,0,1,0,1), then parity 0:
  - CHECK one cycle after the parity transfer, then APPLY with fsm_rst=1 for 4 cycles.
  - Then run=1, fsm_rst=0, keyinput=0xA5, key_ready=0.
- 0xA5 with parity 1:
  - err=1 for exactly one cycle, keyinput stays 0x00, fsm_rst=1.
  - Back in IDLE with key_ready=1; internal try_cnt=1.
- Three consecutive bad-parity loads:
  - After the third CHECK, locked=1 and key_ready=0.
  - A following valid 0xA5 load is ignored (keyinput=0).
  - Pulsing rst low restores the reset values.
- key_clr with key_valid in LOAD after 3 bits:
  - Bit discarded, IDLE, bit_cnt=0.
  - A subsequent 0x3C with parity 0 reaches RUN with keyinput=0x3C.
- One bad load, one good load, then 2 bad loads (MAX_TRIES=3), good-key RUN reached with the key_clr path exercised under KEY_ZEROIZE_EN:
  - No lockout, because the good load cleared try_cnt.
  - With the macro, key_clr in RUN gives keyinput=0x00, fsm_rst=1, IDLE next cycle.
  - Without the macro, key_clr in RUN changes nothing.
- rst driven low on the 2nd APPLY cycle:
  - Same-cycle (asynchronous) keyinput=0, fsm_rst=1, run=0.
  - After release: IDLE with key_ready=1.
